uio_port_arbiter: RTL
=====================

// Module: uio_port_arbiter
// PURPOSE
//   Shares the 8-bit bidirectional uio pad bus of tt_um_giffel1_kims123 among
//   NREQ internal requesters. Round-robin arbitration; each grant runs one
//   framed transfer (write: drive uio_out/uio_oe, read: sample uio_in).
//   A turnaround gap is inserted on every direction change. Sits between the
//   core logic and the top-level uio_* pins.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   HOLD  2  cycles a transfer occupies the bus (>=1)
//   TURN  1  idle cycles (uio_oe=0) on direction change (>=1)
// PORTS
//   clk      in   1       system clock, all logic on rising edge
//   rst_n    in   1       asynchronous, active-low reset
//   ena      in   1       design enable; low blocks new grants
//   req      in   NREQ    per-requester transfer request, level
//   wr       in   NREQ    per-requester direction: 1=write, 0=read
//   wdata    in   NREQ*8  per-requester write byte, requester i at [8i+7:8i]
//   gnt      out  NREQ    one-hot grant, held from grant through done
//   done     out  1       one-cycle pulse ending the granted transfer
//   rdata    out  8       byte captured by last read; holds until next read
//   busy     out  1       1 whenever state != IDLE
//   uio_in   in   8       pad input path
//   uio_out  out  8       pad output path
//   uio_oe   out  8       pad enable, 8'hFF or 8'h00 only
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, gnt=0, done=0, rdata=0, busy=0,
//     uio_out=0, uio_oe=0, rr pointer=0, last_dir=read.
//   FSM states: IDLE, TURN, XFER, DONE.
//   IDLE: if ena && |req, pick first set req at/after rr pointer (wrapping);
//     latch winner index, wr[w], wdata[w]; gnt[w]=1 next cycle.
//     -> TURN if wr[w] != last_dir, else -> XFER. Else stay.
//   TURN: TURN cycles, uio_oe=0, uio_out=0; -> XFER.
//   XFER: HOLD cycles. Write: uio_out=latched byte, uio_oe=8'hFF every cycle.
//     Read: uio_oe=0; rdata <= uio_in at the edge ending the last XFER cycle.
//     -> DONE.
//   DONE: one cycle, done=1, gnt still set, uio_oe=0; last_dir<=latched dir;
//     rr pointer <= (w+1) mod NREQ; -> IDLE (gnt drops, done drops).
//   Latency: req seen in IDLE at edge k -> done high in cycle
//     k+1+HOLD (+TURN if direction changes). Min spacing between grants:
//     one IDLE cycle.
//   req/wr/wdata changes after grant are ignored (latched); req drop
//     mid-transfer does not abort. ena low mid-transfer: transfer completes,
//     no new grant until ena high.
//   Simultaneous requests: only rr order matters; no starvation, each
//     requester served within NREQ grants.
//   rr pointer wraps NREQ-1 -> 0. rdata unchanged by writes.
//   Reset mid-transfer: all outputs return to reset values asynchronously;
//     the transfer is lost, no done pulse.
//   Outputs are registered; no combinational path from req/uio_in to outputs.
// TESTING (NREQ=4, HOLD=2, TURN=1)
//   Reset: rst_n=0 mid-run -> gnt=0, uio_oe=0, uio_out=0, rdata=0, busy=0.
//   req=0001,wr=0001,wdata0=A5 after reset -> TURN 1 cycle, uio_oe=FF and
//     uio_out=A5 for 2 cycles, done pulse with gnt=0001, then IDLE.
//   Then req=0100,wr=0000,uio_in=3C -> TURN 1 cycle oe=00, XFER 2, rdata=3C
//     at done; second read from req1 -> no TURN, done 3 cycles after grant.
//   req=1111 held, all writes -> gnt sequence 0001,0010,0100,1000,0001;
//     no TURN cycles between them.
//   ena=0 with req=0010 -> no grant, busy=0; ena->1 -> grant 0010 next cycle;
//     ena=0 during XFER -> transfer completes with done.
//   req0 deasserted and wdata0 changed during XFER -> uio_out keeps latched
//     byte, done still pulses; rr pointer advances to 1.

Source files
------------

// File: rtl/uio_port_arbiter.sv
// rtl/uio_port_arbiter.sv - round-robin arbiter sharing the uio pad bus among NREQ requesters
// Each grant runs one framed read or write; a turnaround gap separates direction changes.
module uio_port_arbiter #(
   parameter int NREQ = 4,
   parameter int HOLD = 2,
   parameter int TURN = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ena,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ-1:0]   i_wr,
   input  logic [NREQ*8-1:0] i_wdata,
   output logic [NREQ-1:0]   o_gnt,
   output logic              o_done,
   output logic [7:0]        o_rdata,
   output logic              o_busy,
   input  logic [7:0]        i_uio_in,
   output logic [7:0]        o_uio_out,
   output logic [7:0]        o_uio_oe
);

   localparam int IW  = $clog2(NREQ);
   localparam int IW1 = IW + 1;
   localparam int CW  = 8;

   typedef enum logic [1:0] {S_IDLE, S_TURN, S_XFER, S_DONE} state_t;

   state_t            r_state, w_nxt;
   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_ptr, r_win, w_pick, w_win_n;
   logic              r_dir, r_last_dir, w_dir_n, w_found, w_load;
   logic [7:0]        r_byte, w_byte_n;
   logic [IW:0]       w_idx;
   logic [NREQ-1:0]   r_gnt;
   logic              r_done;
   logic [7:0]        r_rdata, r_out, r_oe;

   // First requester at or after the rr pointer, wrapping past NREQ-1.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = {1'b0, r_ptr} + IW1'(i);
         if (w_idx >= IW1'(NREQ)) w_idx = w_idx - IW1'(NREQ);
         if (!w_found && i_req[w_idx[IW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[IW-1:0];
         end
      end
   end

   always_comb begin
      w_nxt  = r_state;
      w_load = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_ena && w_found) begin
               w_load = 1'b1;
               w_nxt  = (i_wr[w_pick] != r_last_dir) ? S_TURN : S_XFER;
            end
         end
         S_TURN:  if (r_cnt == CW'(TURN - 1)) w_nxt = S_XFER;
         S_XFER:  if (r_cnt == CW'(HOLD - 1)) w_nxt = S_DONE;
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
      w_win_n  = w_load ? w_pick : r_win;
      w_dir_n  = w_load ? i_wr[w_pick] : r_dir;
      w_byte_n = w_load ? i_wdata[{w_pick, 3'b000} +: 8] : r_byte;
   end

   // Outputs are registered from the next state so pads change exactly on phase boundaries.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_win      <= '0;
         r_dir      <= 1'b0;
         r_last_dir <= 1'b0;
         r_byte     <= '0;
         r_gnt      <= '0;
         r_done     <= 1'b0;
         r_rdata    <= '0;
         r_out      <= '0;
         r_oe       <= '0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= (w_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + CW'(1);
         r_win   <= w_win_n;
         r_dir   <= w_dir_n;
         r_byte  <= w_byte_n;
         r_gnt   <= (w_nxt != S_IDLE) ? (NREQ'(1) << w_win_n) : '0;
         r_done  <= (w_nxt == S_DONE);
         r_oe    <= (w_nxt == S_XFER && w_dir_n) ? 8'hFF : 8'h00;
         r_out   <= (w_nxt == S_XFER && w_dir_n) ? w_byte_n : 8'h00;
         if (r_state == S_XFER && w_nxt == S_DONE && !r_dir) r_rdata <= i_uio_in;
         if (r_state == S_DONE) begin
            r_last_dir <= r_dir;
            r_ptr      <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
         end
      end
   end

   assign o_gnt     = r_gnt;
   assign o_done    = r_done;
   assign o_rdata   = r_rdata;
   assign o_busy    = (r_state != S_IDLE);
   assign o_uio_out = r_out;
   assign o_uio_oe  = r_oe;

endmodule
